// File: rtl/pulse_emulator.sv
// Detector-pulse source: linear rise over 2^RISE_SHIFT samples, then an exponential tail.
// Optional macro PULSE_EMULATOR_PILEUP_EN: a trigger during a pulse piles up instead of being dropped.
module pulse_emulator #(
    parameter int SIZE_ADC_DATA = 16,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int BASELINE      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    output logic                     busy,
    output logic                     trig_lost,
    output logic [15:0]              pulse_cnt,
    output logic [SIZE_ADC_DATA-1:0] output_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    localparam logic [4:0]               RISE_LAST = 5'((1 << RISE_SHIFT) - 1);
    localparam logic [SIZE_ADC_DATA-1:0] ACC_MAX   = '1;
    // Pedestal clamped once so an oversized BASELINE cannot wrap.
    localparam logic [SIZE_ADC_DATA-1:0] BASE_SAT  =
        (longint'(BASELINE) >= (longint'(1) << SIZE_ADC_DATA)) ? ACC_MAX : SIZE_ADC_DATA'(BASELINE);

    state_t                     r_state;
    logic [SIZE_ADC_DATA-1:0]   r_acc;
    logic [SIZE_ADC_DATA-1:0]   r_step;
    logic [SIZE_ADC_DATA-1:0]   r_amp;
    logic [4:0]                 r_cnt;
    logic [15:0]                r_pulse_cnt;
    logic                       r_trig_lost;
    logic [SIZE_ADC_DATA-1:0]   r_out;

    state_t                     w_state_next;
    logic [SIZE_ADC_DATA-1:0]   w_acc_next;
    logic [SIZE_ADC_DATA-1:0]   w_step_next;
    logic [SIZE_ADC_DATA-1:0]   w_amp_next;
    logic [4:0]                 w_cnt_next;
    logic [15:0]                w_pulse_cnt_next;
    logic                       w_trig_lost_next;

    logic [SIZE_ADC_DATA-1:0]   w_rise_step;
    logic [SIZE_ADC_DATA-1:0]   w_tail;
    logic [SIZE_ADC_DATA:0]     w_out_sum;
    logic [SIZE_ADC_DATA-1:0]   w_out_sat;

    assign w_rise_step = amplitude >> RISE_SHIFT;
    assign w_tail      = r_acc >> DECAY_SHIFT;
    assign w_out_sum   = {1'b0, BASE_SAT} + {1'b0, r_acc};
    assign w_out_sat   = w_out_sum[SIZE_ADC_DATA] ? ACC_MAX : w_out_sum[SIZE_ADC_DATA-1:0];

`ifdef PULSE_EMULATOR_PILEUP_EN
    logic [SIZE_ADC_DATA:0]     w_pile_sum;
    logic [SIZE_ADC_DATA-1:0]   w_pile_sat;

    assign w_pile_sum = {1'b0, r_acc} + {1'b0, amplitude};
    assign w_pile_sat = w_pile_sum[SIZE_ADC_DATA] ? ACC_MAX : w_pile_sum[SIZE_ADC_DATA-1:0];
`endif

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_step_next      = r_step;
        w_amp_next       = r_amp;
        w_cnt_next       = r_cnt;
        w_pulse_cnt_next = r_pulse_cnt;
        w_trig_lost_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (trig) begin
                    w_amp_next       = amplitude;
                    w_step_next      = w_rise_step;
                    w_cnt_next       = 5'd1;
                    w_pulse_cnt_next = r_pulse_cnt + 16'd1;
                    if (RISE_SHIFT == 0) begin
                        w_acc_next   = amplitude;
                        w_state_next = ST_DECAY;
                    end else begin
                        w_acc_next   = w_rise_step;
                        w_state_next = ST_RISE;
                    end
                end
            end

            ST_RISE: begin
                // Last step loads the exact amplitude so truncated steps never miss the peak.
                if (r_cnt == RISE_LAST) begin
                    w_acc_next   = r_amp;
                    w_state_next = ST_DECAY;
                end else begin
                    w_acc_next = r_acc + r_step;
                    w_cnt_next = r_cnt + 5'd1;
                end
`ifdef PULSE_EMULATOR_PILEUP_EN
                if (trig) begin
                    w_acc_next       = w_pile_sat;
                    w_state_next     = ST_DECAY;
                    w_pulse_cnt_next = r_pulse_cnt + 16'd1;
                end
`else
                w_trig_lost_next = trig;
`endif
            end

            ST_DECAY: begin
                if (w_tail == '0) begin
                    w_acc_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_acc_next = r_acc - w_tail;
                end
`ifdef PULSE_EMULATOR_PILEUP_EN
                if (trig) begin
                    w_acc_next       = w_pile_sat;
                    w_state_next     = ST_DECAY;
                    w_pulse_cnt_next = r_pulse_cnt + 16'd1;
                end
`else
                w_trig_lost_next = trig;
`endif
            end

            default: begin
                w_acc_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_step      <= '0;
            r_amp       <= '0;
            r_cnt       <= '0;
            r_pulse_cnt <= '0;
            r_trig_lost <= 1'b0;
            r_out       <= BASE_SAT;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_step      <= w_step_next;
            r_amp       <= w_amp_next;
            r_cnt       <= w_cnt_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_trig_lost <= w_trig_lost_next;
            r_out       <= w_out_sat;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign trig_lost   = r_trig_lost;
    assign pulse_cnt   = r_pulse_cnt;
    assign output_data = r_out;

endmodule

// File: tb/tb_pulse_emulator.sv
// Scoreboard bench for pulse_emulator: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pulse_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic [15:0] amplitude;

    logic        busy, trig_lost;
    logic [15:0] pulse_cnt, output_data;
    logic        busy_b, trig_lost_b;
    logic [15:0] pulse_cnt_b, output_data_b;

    pulse_emulator #(
        .SIZE_ADC_DATA(16), .RISE_SHIFT(2), .DECAY_SHIFT(4), .BASELINE(0)
    ) u_dut (
        .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude),
        .busy(busy), .trig_lost(trig_lost), .pulse_cnt(pulse_cnt), .output_data(output_data)
    );

    // Same stimulus with a high pedestal to exercise output saturation.
    pulse_emulator #(
        .SIZE_ADC_DATA(16), .RISE_SHIFT(2), .DECAY_SHIFT(4), .BASELINE(65000)
    ) u_dut_base (
        .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude),
        .busy(busy_b), .trig_lost(trig_lost_b), .pulse_cnt(pulse_cnt_b), .output_data(output_data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    out;
        int    out2;
        bit    busy;
        bit    lost;
        int    pcnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_pcnt = 16'd0;
    int          acc_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Monitor: one record per edge, matched by edge number.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc_cnt ||
                output_data !== 16'(e.out) || busy !== e.busy || trig_lost !== e.lost ||
                pulse_cnt !== 16'(e.pcnt) || output_data_b !== 16'(e.out2) ||
                busy_b !== e.busy || trig_lost_b !== e.lost || pulse_cnt_b !== 16'(e.pcnt)) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d out=%0d/%0d busy=%0b/%0b lost=%0b/%0b pcnt=%0d/%0d out_base=%0d/%0d busy_base=%0b lost_base=%0b pcnt_base=%0d (actual/required)",
                         e.name, cyc_cnt, e.cyc, output_data, e.out, busy, e.busy, trig_lost, e.lost,
                         pulse_cnt, e.pcnt, output_data_b, e.out2, busy_b, trig_lost_b, pulse_cnt_b);
            end else begin
                $display("ok   %s cyc=%0d out=%0d busy=%0b lost=%0b pcnt=%0d out_base=%0d",
                         e.name, cyc_cnt, output_data, busy, trig_lost, pulse_cnt, output_data_b);
            end
        end
    end

    // Drive inputs for the next edge and queue what must be seen after it.
    task automatic drive(input bit rst, input bit t, input logic [15:0] a,
                         input int e_out, input bit e_busy, input bit e_lost, input string nm);
        exp_t e;
        reset     = rst;
        trig      = t;
        amplitude = a;
        e.cyc  = cyc_cnt + 1;
        e.name = nm;
        e.out  = e_out;
        e.out2 = sat16(65000 + e_out);
        e.busy = e_busy;
        e.lost = e_lost;
        e.pcnt = int'(exp_pcnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Append the exponential tail: acc -= acc>>4 until the tail term is zero, then 0.
    task automatic extend_decay();
        while ((acc_q[$] >> 4) != 0)
            acc_q.push_back(acc_q[$] - (acc_q[$] >> 4));
        acc_q.push_back(0);
    endtask

    // One triggered pulse; acc_q holds acc after each edge, last entry is the return to idle.
    task automatic run_pulse(input logic [15:0] amp, input int hold_j,
                             input logic [15:0] hold_amp, input string nm);
        int n;
        n = acc_q.size() - 1;
        exp_pcnt = exp_pcnt + 16'd1;
        for (int j = 0; j <= n + 1; j++) begin
            bit          t;
            logic [15:0] a;
            t = (j == 0) || (j == hold_j);
            a = (j == 0) ? amp : ((j == hold_j) ? hold_amp : 16'd0);
            drive(1'b0, t, a, (j == 0) ? 0 : acc_q[j-1], (j < n), (j == hold_j) && (j != 0), nm);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        trig = 1'b0;
        amplitude = 16'd0;
        @(posedge clk);
        #1;

        // Reset, then idle.
        exp_pcnt = 16'd0;
        drive(1'b1, 1'b0, 16'd0, 0, 1'b0, 1'b0, "reset");
        drive(1'b1, 1'b1, 16'd777, 0, 1'b0, 1'b0, "reset_trig");
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 16'd0, 0, 1'b0, 1'b0, "idle");

        // Amplitude 1000: rise 250/500/750/1000 then tail.
        acc_q = '{250, 500, 750, 1000, 938, 880, 825};
        extend_decay();
        run_pulse(16'd1000, -1, 16'd0, "pulse1000");

        // Amplitude 1003: exact peak after truncated steps.
        acc_q = '{250, 500, 750, 1003};
        extend_decay();
`ifndef PULSE_EMULATOR_PILEUP_EN
        // trig on the edge that returns to idle is dropped, not accepted.
        run_pulse(16'd1003, acc_q.size() - 1, 16'd400, "pulse1003_endtrig");
`else
        run_pulse(16'd1003, -1, 16'd0, "pulse1003");
`endif

`ifndef PULSE_EMULATOR_PILEUP_EN
        // trig during the cycle showing 938 is dropped for one cycle.
        acc_q = '{250, 500, 750, 1000, 938, 880, 825};
        extend_decay();
        run_pulse(16'd1000, 6, 16'd500, "pulse1000_lost");
`endif

        // Zero amplitude still runs rise plus one decay cycle.
        acc_q = '{0, 0, 0, 0};
        extend_decay();
        run_pulse(16'd0, -1, 16'd0, "pulse0");

        // Reset during decay at the 880 sample, with a simultaneous trig.
        exp_pcnt = exp_pcnt + 16'd1;
        drive(1'b0, 1'b1, 16'd1000, 0,   1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    250, 1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    500, 1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    750, 1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    1000, 1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    938, 1'b1, 1'b0, "abort");
        drive(1'b0, 1'b0, 16'd0,    880, 1'b1, 1'b0, "abort");
        exp_pcnt = 16'd0;
        drive(1'b1, 1'b1, 16'd1000, 0, 1'b0, 1'b0, "abort_reset");
        drive(1'b0, 1'b0, 16'd0,    0, 1'b0, 1'b0, "abort_idle");

`ifdef PULSE_EMULATOR_PILEUP_EN
        // Pile-up in RISE (no clamp), then at the top of DECAY (clamps to 65535).
        exp_pcnt = exp_pcnt + 16'd1;
        drive(1'b0, 1'b1, 16'd60000, 0,     1'b1, 1'b0, "pileup");
        drive(1'b0, 1'b0, 16'd0,     15000, 1'b1, 1'b0, "pileup");
        exp_pcnt = exp_pcnt + 16'd1;
        drive(1'b0, 1'b1, 16'd10000, 30000, 1'b1, 1'b0, "pileup_rise");
        drive(1'b0, 1'b0, 16'd0,     40000, 1'b1, 1'b0, "pileup");
        exp_pcnt = exp_pcnt + 16'd1;
        drive(1'b0, 1'b1, 16'd60000, 37500, 1'b1, 1'b0, "pileup_decay");
        drive(1'b0, 1'b0, 16'd0,     65535, 1'b1, 1'b0, "pileup_clamp");
        drive(1'b0, 1'b0, 16'd0,     61440, 1'b1, 1'b0, "pileup_tail");
        exp_pcnt = 16'd0;
        drive(1'b1, 1'b0, 16'd0,     0,     1'b0, 1'b0, "pileup_reset");
        drive(1'b0, 1'b0, 16'd0,     0,     1'b0, 1'b0, "pileup_idle");
`endif

        reset = 1'b0;
        trig = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
